// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the unified-memory port arbiter.
//   state_e     : arbiter FSM states (IDLE, ACCESS, RESP)
//   grant_e     : which requester owns the current transaction
//   MEM_LAT_MAX : largest supported memory latency
package mem_arb_pkg;

  localparam int unsigned MEM_LAT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch (I) and data (D) ports.
// Build option: MEM_ARB_RR_EN selects round-robin on contention; otherwise
// D always beats I.
// Ports:
//   i_req, d_req : pending requests
//   last_gnt     : previous winner (present only with MEM_ARB_RR_EN)
//   valid_c      : at least one request pending
//   winner_c     : selected port, meaningful when valid_c is high
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef MEM_ARB_RR_EN
  input  grant_e last_gnt,
`endif
  output logic   valid_c,
  output grant_e winner_c
);

  // Winner selection
  always_comb begin
    valid_c  = i_req | d_req;
    winner_c = d_req ? GNT_D : GNT_I;
`ifdef MEM_ARB_RR_EN
    // On contention, hand the grant to whoever did not win last time
    if (i_req && d_req) begin
      winner_c = (last_gnt == GNT_D) ? GNT_I : GNT_D;
    end
`endif
  end

endmodule : mem_arb_pick

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the instruction-fetch
// port (read-only) and the data port (read/write). Each access is granted in
// IDLE, held stable on the memory side for MEM_LAT cycles in ACCESS, and
// acknowledged with a one-cycle pulse in RESP.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration (see mem_arb_pick).
// Ports:
//   clk, clrn                  : clock, synchronous active-low reset
//   i_req/i_addr               : fetch request and address (held until i_ack)
//   i_ack/i_rdata              : fetch completion pulse and registered word
//   d_req/d_we/d_addr/d_wdata  : data request (held until d_ack)
//   d_ack/d_rdata              : data completion pulse and registered load data
//   m_en/m_we/m_addr/m_wdata   : memory-side command, all registered
//   m_rdata                    : memory read data, valid MEM_LAT cycles after m_en rises
// MEM_LAT legal range is 1..MEM_LAT_MAX.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  // Counter never wraps: it is reloaded with MEM_LAT-1 on every grant
  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  grant_e            gnt_q, gnt_nxt;
  logic              i_ack_nxt, d_ack_nxt;
  logic              m_en_nxt, m_we_nxt;
  logic [ADDR_W-1:0] m_addr_nxt;
  logic [DATA_W-1:0] m_wdata_nxt;
  logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt;
  logic              pick_valid_c;
  grant_e            pick_winner_c;

`ifdef MEM_ARB_RR_EN
  grant_e            last_q, last_nxt;
`endif

  mem_arb_pick u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
`ifdef MEM_ARB_RR_EN
    .last_gnt (last_q),
`endif
    .valid_c  (pick_valid_c),
    .winner_c (pick_winner_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    gnt_nxt     = gnt_q;
    i_ack_nxt   = 1'b0;
    d_ack_nxt   = 1'b0;
    m_en_nxt    = m_en;
    m_we_nxt    = m_we;
    m_addr_nxt  = m_addr;
    m_wdata_nxt = m_wdata;
    i_rdata_nxt = i_rdata;
    d_rdata_nxt = d_rdata;
`ifdef MEM_ARB_RR_EN
    last_nxt    = last_q;
`endif

    case (state_q)
      IDLE: begin
        m_en_nxt = 1'b0;
        m_we_nxt = 1'b0;
        if (pick_valid_c) begin
          gnt_nxt   = pick_winner_c;
          cnt_nxt   = CNT_LOAD;
          m_en_nxt  = 1'b1;
          state_nxt = ACCESS;
`ifdef MEM_ARB_RR_EN
          last_nxt  = pick_winner_c;
`endif
          if (pick_winner_c == GNT_D) begin
            m_addr_nxt  = d_addr;
            m_we_nxt    = d_we;
            m_wdata_nxt = d_wdata;
          end else begin
            m_addr_nxt  = i_addr;
            m_we_nxt    = 1'b0;
          end
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          // Last latency cycle: m_rdata is valid now
          m_en_nxt  = 1'b0;
          m_we_nxt  = 1'b0;
          state_nxt = RESP;
          if (gnt_q == GNT_I) begin
            i_rdata_nxt = m_rdata;
            i_ack_nxt   = 1'b1;
          end else begin
            if (!m_we) begin
              d_rdata_nxt = m_rdata;
            end
            d_ack_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end

      RESP: begin
        // Ack pulse is on the bus this cycle; requests wait until IDLE
        m_en_nxt  = 1'b0;
        m_we_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        m_en_nxt  = 1'b0;
        m_we_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= GNT_D;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
`ifdef MEM_ARB_RR_EN
      last_q  <= GNT_D;
`endif
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      gnt_q   <= gnt_nxt;
      i_ack   <= i_ack_nxt;
      d_ack   <= d_ack_nxt;
      m_en    <= m_en_nxt;
      m_we    <= m_we_nxt;
      m_addr  <= m_addr_nxt;
      m_wdata <= m_wdata_nxt;
      i_rdata <= i_rdata_nxt;
      d_rdata <= d_rdata_nxt;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_nxt;
`endif
    end
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT = 1, 2, 15), each with
// a fixed-latency memory model, randomized I/D requesters, a transaction-level
// reference (one access at a time, LAT+2 cycles apart) feeding a scoreboard
// queue, and a monitor that checks acks and read data as they appear.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: bound expired", name);
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 15);

    typedef struct {
      bit          port_d;
      bit          we;
      int          cyc;
      logic [31:0] rdata;
    } exp_t;

    logic        clrn = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_ack, d_ack, m_en, m_we;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

    exp_t        q[$];
    logic [31:0] mem[64];
    logic [31:0] ref_mem[64];
    int          en_cyc = 0;
    logic        rst_edge = 1'b0;
    int          free_edge = 0;
    bit          last_d = 1'b1;
    logic [31:0] cur_i = '0, cur_d = '0;
    logic [31:0] lat_addr = '0, lat_wdata = '0;
    logic        lat_we = 1'b0;
    bit          done_l = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk     (clk),
      .clrn    (clrn),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_ack   (i_ack),
      .i_rdata (i_rdata),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_ack   (d_ack),
      .d_rdata (d_rdata),
      .m_en    (m_en),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata)
    );

    // Memory: data only valid in the cycle LAT after m_en rose
    assign m_rdata = (m_en && en_cyc == int'(LAT - 1)) ? mem[m_addr[7:2]] : 32'hBADD_0BAD;

    always @(posedge clk) begin
      rst_edge <= !clrn;
      en_cyc   <= m_en ? en_cyc + 1 : 0;
      if (m_en && m_we && en_cyc == int'(LAT - 1)) mem[m_addr[7:2]] <= m_wdata;
    end

    // Memory-side checks: bounded m_en window, command held stable
    always @(negedge clk) begin
      if (m_en) begin
        chk($sformatf("L%0d m_en_window", g), 192'(en_cyc < int'(LAT)), 192'(1));
        if (en_cyc == 0) begin
          lat_addr  = m_addr;
          lat_we    = m_we;
          lat_wdata = m_wdata;
        end else begin
          chk($sformatf("L%0d m_side_hold", g), 192'({m_addr, m_we, m_wdata}),
              192'({lat_addr, lat_we, lat_wdata}));
        end
      end
    end

    // Reference: one access at a time, the arbiter samples again LAT+2 edges after a grant
    always @(negedge clk) begin
      exp_t e;
      if (!clrn) begin
        while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
        free_edge = cyc + 2;
        last_d    = 1'b1;
      end else if (cyc + 1 >= free_edge && (i_req || d_req)) begin
        e.port_d = d_req && (!i_req || !RR || !last_d);
        e.cyc    = cyc + 1 + int'(LAT);
        e.we     = e.port_d && d_we;
        e.rdata  = '0;
        if (!e.port_d)   e.rdata = ref_mem[i_addr[7:2]];
        else if (!d_we)  e.rdata = ref_mem[d_addr[7:2]];
        else             ref_mem[d_addr[7:2]] = d_wdata;
        last_d    = e.port_d;
        free_edge = cyc + 1 + int'(LAT) + 2;
        q.push_back(e);
      end
    end

    // Monitor: acks and registered read data against the scoreboard
    always @(negedge clk) begin
      exp_t e;
      logic exp_i, exp_d;
      if (rst_edge) begin
        cur_i = '0;
        cur_d = '0;
        chk($sformatf("L%0d reset_outputs", g),
            192'({i_ack, d_ack, m_en, m_we, m_addr, m_wdata, i_rdata, d_rdata}), 192'(0));
      end else begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          fail_now($sformatf("L%0d ack_missing_cyc%0d", g, q[0].cyc));
          void'(q.pop_front());
        end
        exp_i = 1'b0;
        exp_d = 1'b0;
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          exp_i = !e.port_d;
          exp_d = e.port_d;
          if (!e.port_d)  cur_i = e.rdata;
          else if (!e.we) cur_d = e.rdata;
        end
        if (i_ack || d_ack || exp_i || exp_d) begin
          chk($sformatf("L%0d acks_cyc%0d", g, cyc), 192'({i_ack, d_ack}), 192'({exp_i, exp_d}));
          chk($sformatf("L%0d rdata_cyc%0d", g, cyc), 192'({i_rdata, d_rdata}), 192'({cur_i, cur_d}));
        end
      end
    end

    task automatic wait_i_ack();
      int n = 0;
      do begin @(negedge clk); n++; end while (!i_ack && n < 400);
      if (!i_ack) fail_now($sformatf("L%0d i_ack_timeout", g));
      @(posedge clk);
      #1 i_req = 1'b0;
    endtask

    task automatic wait_d_ack();
      int n = 0;
      do begin @(negedge clk); n++; end while (!d_ack && n < 400);
      if (!d_ack) fail_now($sformatf("L%0d d_ack_timeout", g));
      @(posedge clk);
      #1 d_req = 1'b0;
    endtask

    task automatic run_i(input int n);
      for (int k = 0; k < n; k++) begin
        repeat (1 + $urandom_range(0, 3)) @(posedge clk);
        #1 i_addr = 32'($urandom_range(0, 63)) << 2;
        i_req = 1'b1;
        wait_i_ack();
      end
    endtask

    task automatic run_d(input int n);
      for (int k = 0; k < n; k++) begin
        repeat (1 + $urandom_range(0, 3)) @(posedge clk);
        #1 d_addr = 32'($urandom_range(0, 63)) << 2;
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
        d_req   = 1'b1;
        wait_d_ack();
      end
    endtask

    initial begin
      logic [31:0] v;
      for (int k = 0; k < 64; k++) begin
        v = (k == 1) ? 32'h8C01_0000 : $urandom;
        mem[k]     <= v;
        ref_mem[k] = v;
      end
      // Reset with both ports requesting, then contention on release
      clrn    = 1'b0;
      i_req   = 1'b1;
      i_addr  = 32'h0000_0004;
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h0000_0050;
      d_wdata = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1 clrn = 1'b1;
      fork
        wait_i_ack();
        wait_d_ack();
      join
      // Abort an I read right after it is granted
      repeat (3) @(posedge clk);
      #1 i_addr = 32'h0000_0008;
      i_req = 1'b1;
      @(posedge clk);
      #1 chk($sformatf("L%0d abort_granted", g), 192'(m_en), 192'(1));
      clrn  = 1'b0;
      i_req = 1'b0;
      @(posedge clk);
      #1 clrn = 1'b1;
      repeat (2) @(posedge clk);
      // Random traffic on both ports
      fork
        run_i(25);
        run_d(25);
      join
      repeat (LAT + 4) @(posedge clk);
      done_l = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(lane[0].done_l && lane[1].done_l && lane[2].done_l) && t < 40000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 40000) fail_now("global_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_mem_port_arbiter
